shift_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational right shifter in the ALU datapath.
- Supports four shift modes: logical right, arithmetic right, logical left and rotate right.
- Produces a carry-out flag in addition to Z and N.
- Runs a 2-stage valid/ready pipeline with full backpressure, so the ALU control unit can issue one shift per cycle and stall cleanly.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_core.sv | 75 +++++++
 rtl/shift_unit_pipe.sv | 82 ++++++++
 tb/tb_shift_unit_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined shift unit: op encoding and result flags.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SRL = 2'b00,
    SHIFT_SRA = 2'b01,
    SHIFT_SLL = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } shift_flags_t;

endpackage

// File: rtl/shift_core.sv
// Combinational log2 barrel shifter: (a, shamt, op) -> (result, carry-out).
// Right shifts run on {a, 1'b0} so the last bit shifted out lands in bit 0;
// SLL reuses the same network on the bit-reversed operand.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_op_t          op,
  output logic [WIDTH-1:0]   result,
  output logic               c
);

  localparam logic [SHAMT_W-1:0] AMT_W  = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] AMT_W1 = SHAMT_W'(WIDTH + 1);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic [WIDTH:0]     rsh;
  logic [SHAMT_W-1:0] amt;
  logic               fill;
  logic [WIDTH-1:0]   rot;
  logic [SHAMT_W-1:0] r_amt;

  // Right-shift network; amounts past the operand are clamped so the
  // vector drains to zero (logical) or to the sign (arithmetic).
  always_comb begin
    rsh  = {a, 1'b0};
    fill = 1'b0;
    amt  = (shamt > AMT_W) ? AMT_W1 : shamt;
    case (op)
      SHIFT_SRA: begin
        fill = a[WIDTH-1];
        amt  = (shamt >= AMT_W) ? AMT_W : shamt;
      end
      SHIFT_SLL: rsh = {bit_rev(a), 1'b0};
      default: ;
    endcase
    for (int k = 0; k < SHAMT_W; k++)
      if (amt[k])
        rsh = (rsh >> (1 << k)) |
              ({(WIDTH+1){fill}} & ~({(WIDTH+1){1'b1}} >> (1 << k)));
  end

  // Rotate network over r = shamt mod WIDTH.
  always_comb begin
    r_amt = SHAMT_W'(int'(shamt) % WIDTH);
    rot   = a;
    for (int k = 0; k < SHAMT_W; k++)
      if (r_amt[k] && ((1 << k) < WIDTH))
        rot = (rot >> (1 << k)) | (rot << (WIDTH - (1 << k)));
  end

  // Select result; ROR carry is the new MSB whenever any rotation was asked.
  always_comb begin
    result = rsh[WIDTH:1];
    c      = rsh[0];
    case (op)
      SHIFT_ROR: begin
        result = rot;
        c      = (shamt != '0) & rot[WIDTH-1];
      end
      SHIFT_SLL: result = bit_rev(rsh[WIDTH:1]);
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage valid/ready shift pipeline: operand register, shift core,
// result/flag register. Full backpressure, in-order, 1 op/cycle.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_z,
  output logic               out_n,
  output logic               out_c
);

  logic               s1_valid, s2_valid, adv2;
  logic [WIDTH-1:0]   s1_a;
  logic [SHAMT_W-1:0] s1_shamt;
  shift_op_t          s1_op;
  logic [WIDTH-1:0]   core_result;
  logic               core_c;
  shift_flags_t       flags;

  // Stage 2 can take new data when empty or draining; stage 1 likewise
  // when empty or moving into stage 2. No path from in_valid.
  assign adv2     = ~s2_valid | out_ready;
  assign in_ready = ~s1_valid | adv2;

  // Stage 1: capture the request on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_shamt <= '0;
      s1_op    <= SHIFT_SRL;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= in_a;
        s1_shamt <= in_shamt;
        s1_op    <= shift_op_t'(in_op);
      end
    end
  end

  shift_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
    .a      (s1_a),
    .shamt  (s1_shamt),
    .op     (s1_op),
    .result (core_result),
    .c      (core_c)
  );

  // Stage 2: register result and flags; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      flags      <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= core_result;
        flags      <= '{z: (core_result == '0), n: core_result[WIDTH-1], c: core_c};
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_z     = flags.z;
  assign out_n     = flags.n;
  assign out_c     = flags.c;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe (WIDTH=32): directed cases,
// backpressure, reset mid-flight, then randomized traffic vs a model.
module tb_shift_unit_pipe;

  localparam int W  = 32;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic          out_z, out_n, out_c;

  shift_unit_pipe #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_z(out_z), .out_n(out_n), .out_c(out_c)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W+2:0] exp_q[$];   // {c, n, z, result}
  logic         hold_prev = 1'b0;
  logic [W+2:0] snap_prev = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: straight from the shift rules, using native operators.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input int s, input logic [1:0] op);
    logic [W-1:0] r;
    logic         c;
    int           rr;
    r = a;
    c = 1'b0;
    if (s != 0) begin
      case (op)
        2'b00: if (s <= W) begin r = a >> s; c = a[s-1]; end else begin r = '0; c = 1'b0; end
        2'b01: if (s < W) begin r = $signed(a) >>> s; c = a[s-1]; end
               else begin r = {W{a[W-1]}}; c = a[W-1]; end
        2'b10: if (s <= W) begin r = a << s; c = a[W-s]; end else begin r = '0; c = 1'b0; end
        default: begin rr = s % W; r = (a >> rr) | (a << (W - rr)); c = r[W-1]; end
      endcase
    end
    return {c, r[W-1], (r == '0), r};
  endfunction

  function automatic logic [W+2:0] dut_out();
    return {out_c, out_n, out_z, out_result};
  endfunction

  // One cycle from a negedge: score handshakes, check hold stability.
  task automatic cycle();
    logic [W+2:0] e;
    #1;
    if (hold_prev) chk("hold_stable", dut_out(), snap_prev);
    hold_prev = out_valid && !out_ready;
    snap_prev = dut_out();
    if (out_valid && out_ready) begin
      chk("q_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", dut_out(), e);
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(in_a, int'(in_shamt), in_op));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed op on an idle pipe: check latency and the exact result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [SW-1:0] s,
                        input logic [1:0] op, input logic [W-1:0] er,
                        input logic ez, input logic en, input logic ec);
    in_a = a; in_shamt = s; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); @(negedge clk);
    #1 chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, out_result, er);
    chk({tag, "_znc"}, {out_z, out_n, out_c}, {ez, en, ec});
    chk({tag, "_model"}, dut_out(), model(a, int'(s), op));
    @(negedge clk);
  endtask

  logic [W-1:0]  bp_a[4];
  logic [SW-1:0] bp_s[4];
  logic [1:0]    bp_op[4];
  logic [W+3:0]  bp_snap;
  logic          acc;
  int            idx;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outs", {out_result, out_z, out_n, out_c}, 0);
    @(negedge clk);

    // directed
    run_op("srl31",  32'h8000_0000, 6'd31, 2'b00, 32'h0000_0001, 0, 0, 0);
    run_op("srl32",  32'h8000_0000, 6'd32, 2'b00, 32'h0000_0000, 1, 0, 1);
    run_op("sra4",   32'h8000_00F0, 6'd4,  2'b01, 32'hF800_000F, 0, 1, 0);
    run_op("sra40",  32'h8000_00F0, 6'd40, 2'b01, 32'hFFFF_FFFF, 0, 1, 1);
    run_op("sll32",  32'h0000_0001, 6'd32, 2'b10, 32'h0000_0000, 1, 0, 1);
    run_op("sll33",  32'h0000_0001, 6'd33, 2'b10, 32'h0000_0000, 1, 0, 0);
    run_op("ror33",  32'h0000_0001, 6'd33, 2'b11, 32'h8000_0000, 0, 1, 1);
    run_op("ror0",   32'h0000_0001, 6'd0,  2'b11, 32'h0000_0001, 0, 0, 0);
    run_op("ror32",  32'h8000_0001, 6'd32, 2'b11, 32'h8000_0001, 0, 1, 1);

    // backpressure: 4 ops offered while the consumer stalls 5 cycles
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = $urandom; bp_s[i] = SW'($urandom_range(0, 63)); bp_op[i] = 2'($urandom_range(0, 3));
    end
    idx = 0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1; in_a = bp_a[idx]; in_shamt = bp_s[idx]; in_op = bp_op[idx];
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, int'(in_shamt), in_op));
        idx++;
      end
      if (cyc == 2) bp_snap = {out_valid, dut_out()};
      if (cyc > 2)  chk("bp_stable", {out_valid, dut_out()}, bp_snap);
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    hold_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_a = bp_a[idx]; in_shamt = bp_s[idx]; in_op = bp_op[idx]; end
      #1;
      chk("bp_drain_vld", out_valid, 1);
      acc = in_valid && in_ready;
      cycle();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_out", exp_q.size(), 0);
    chk("bp_all_in", idx, 4);

    // reset with both stages full; a request during reset must be dropped
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_shamt = SW'($urandom_range(1, 31)); in_op = 2'b00;
      cycle();
    end
    #1 chk("mid_full", {out_valid, in_ready}, 2'b10);
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    hold_prev = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      #1 chk("mid_no_stale", out_valid, 0);
      cycle();
    end

    // randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: in_a = '0;
        1: in_a = '1;
        2: in_a = 32'h8000_0000;
        3: in_a = 32'h0000_0001;
        default: in_a = $urandom;
      endcase
      in_shamt = SW'($urandom_range(0, 63));
      in_op    = 2'($urandom_range(0, 3));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
    chk("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
